// File: rtl/counter_updn_mod.sv
// Up/down modulo-(MAX_VAL+1) counter with parallel load, wrap or saturate mode,
// registered compare flag and a combinational carry for building longer chains.
module counter_updn_mod #(
    parameter int          WIDTH   = 8,
    parameter int unsigned MAX_VAL = 255,
    parameter bit          SAT     = 1'b0
) (
    input  logic             CLK,
    input  logic             RST_,
    input  logic             CE,
    input  logic             CI,
    input  logic             M,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] CMP,
    output logic [WIDTH-1:0] Q,
    output logic             CO,
    output logic             TC,
    output logic             MATCH
);

    localparam logic [WIDTH-1:0] MAX_Q = MAX_VAL[WIDTH-1:0];

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("counter_updn_mod: WIDTH must be in 2..32");
        end
        if (MAX_VAL == 0 || 64'(MAX_VAL) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
            $error("counter_updn_mod: MAX_VAL must be in 1..2**WIDTH-1");
        end
    endgenerate

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] q_inc;
    logic [WIDTH-1:0] q_dec;
    logic             co_reg;
    logic             co_next;
    logic             match_reg;
    logic             count_en;
    logic             at_zero;
    logic             at_max;

    assign count_en = CE & CI;
    assign at_zero  = (q_reg == '0);
    assign at_max   = (q_reg == MAX_Q);
    assign q_inc    = q_reg + 1'b1;
    assign q_dec    = q_reg - 1'b1;

    // Carry-out is purely combinational so a cascaded stage sees it in the same cycle.
    assign TC = count_en & (M ? at_zero : at_max);

    always_comb begin
        q_next  = q_reg;
        co_next = 1'b0;
        if (LD) begin
            q_next = (D > MAX_Q) ? MAX_Q : D;
        end else if (count_en) begin
            if (!M) begin
                if (!at_max) begin
                    q_next  = q_inc;
                    co_next = SAT & (q_inc == MAX_Q);
                end else begin
                    q_next  = SAT ? q_reg : '0;
                    co_next = ~SAT;
                end
            end else begin
                if (!at_zero) begin
                    q_next  = q_dec;
                    co_next = SAT & (q_dec == '0);
                end else begin
                    q_next  = SAT ? q_reg : MAX_Q;
                    co_next = ~SAT;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_) begin
            q_reg     <= '0;
            co_reg    <= 1'b0;
            match_reg <= 1'b0;
        end else begin
            q_reg     <= q_next;
            co_reg    <= co_next;
            match_reg <= (q_next == CMP);
        end
    end

    assign Q     = q_reg;
    assign CO    = co_reg;
    assign MATCH = match_reg;

endmodule

// File: doc/counter_updn_mod.md
COUNTER_UPDN_MOD -- requirements
Module: counter_updn_mod

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits; legal range 2..32.
REQ-002 Parameter MAX_VAL, default 255, terminal count (modulus-1); legal range 1..2**WIDTH-1.
REQ-003 Parameter SAT, default 0; 0 = wrap at terminal, 1 = saturate at terminal.
REQ-004 CLK  in  1  single clock; all state updates on rising edge.
REQ-005 RST_  in  1  synchronous reset, active-low.
REQ-006 CE  in  1  count enable.
REQ-007 CI  in  1  cascade carry-in; count enable is CE & CI; tie to 1 when not cascaded.
REQ-008 M  in  1  direction; 0 = up, 1 = down.
REQ-009 LD  in  1  synchronous parallel load.
REQ-010 D  in  WIDTH  load value.
REQ-011 CMP  in  WIDTH  compare value for MATCH.
REQ-012 Q  out  WIDTH  registered count.
REQ-013 CO  out  1  registered terminal-event pulse.
REQ-014 TC  out  1  combinational cascade carry-out for the next stage's CI.
REQ-015 MATCH  out  1  registered compare flag.

Function
REQ-016 Priority at each rising CLK edge: RST_=0, then LD=1, then enabled count (CE & CI = 1), else hold.
REQ-017 LD acts regardless of CE and CI: Q <= D when D <= MAX_VAL, else Q <= MAX_VAL (clamp); CO <= 0.
REQ-018 Up count (M=0), enabled, Q < MAX_VAL: Q <= Q+1, CO <= 0.
REQ-019 Up count, enabled, Q = MAX_VAL: SAT=0 gives Q <= 0, CO <= 1; SAT=1 gives Q holds MAX_VAL, CO <= 0.
REQ-020 Down count (M=1), enabled, Q > 0: Q <= Q-1, CO <= 0.
REQ-021 Down count, enabled, Q = 0: SAT=0 gives Q <= MAX_VAL, CO <= 1; SAT=1 gives Q holds 0, CO <= 0.
REQ-022 SAT=1 only: CO <= 1 on the enabled edge that moves Q onto the terminal value for the current direction (MAX_VAL up, 0 down); later enabled edges at terminal give CO <= 0.
REQ-023 CO is a single-cycle pulse: any edge without a qualifying event (hold, load, non-terminal count) gives CO <= 0.
REQ-024 TC = CE & CI & (M ? (Q == 0) : (Q == MAX_VAL)), evaluated combinationally from current Q; TC is independent of SAT and LD.
REQ-025 Cascading: stage k TC drives stage k+1 CI, with shared CE, M and CLK; the chain behaves as one counter of the combined modulus with no extra latency.
REQ-026 MATCH <= (Q_next == CMP) at every edge, where Q_next is the value written to Q at that edge and CMP is sampled at that edge; so MATCH = (Q == CMP) after any edge.
REQ-027 Arithmetic is modulo 2**WIDTH internally; Q never exceeds MAX_VAL after reset or load.
REQ-028 A change on M takes effect at the first edge at which it is sampled; there are no pipeline stages and count latency is 1 cycle.
REQ-029 Q exits reset at 0; the first enabled edge after reset release gives Q = 1 (up) or Q = MAX_VAL (down).

Reset
REQ-030 RST_=0 at a rising edge sets Q = 0, CO = 0, MATCH = 0, overriding LD, CE and CI.
REQ-031 Reset during an active count or load takes effect at that same edge; no partial update is retained.
REQ-032 Before the first clock edge, Q, CO and MATCH are undefined; RST_ must be held low for at least 1 edge.
REQ-033 TC follows REQ-024 during reset (Q = 0, so TC = CE & CI & M).

Verification
REQ-034 WIDTH=4, MAX_VAL=9, SAT=0, CE=CI=1, M=0, 12 edges from reset -> Q: 1..9, 0, 1, 2; CO=1 only in the cycle after Q 9->0; TC=1 while Q=9.
REQ-035 Same config, M=1 from Q=0 -> Q=9, CO=1 for one cycle; TC=1 while Q=0; then Q=8.
REQ-036 SAT=1, MAX_VAL=9, up from Q=7 for 4 edges -> Q: 8, 9, 9, 9; CO=1 only after the 8->9 edge.
REQ-037 LD=1 with D=13, MAX_VAL=9, CE=0 -> Q=9 next cycle, CO=0; LD=1 with RST_=0 at the same edge -> Q=0.
REQ-038 Two WIDTH=4, MAX_VAL=9 stages cascaded (TC->CI), up, 100 edges from reset -> {Q_hi,Q_lo} = 0,0; each edge increments BCD-style; hi-stage CO=1 once, at 99->00.
REQ-039 CMP=5, counting up from reset -> MATCH=1 exactly in the cycle Q=5; changing CMP to the current Q updates MATCH at the next edge.
